cpu_run_ctrl: RTL

Debug run/step controller for the board-level multi-cycle CPU. It generates the CPU clock-enable and the 5-beat one-hot phase (fetch .. writeback). It supports single-beat stepping, single-instruction stepping, free-run and PC breakpoints, and exports beat/instruction counters for the 7-seg/LED debug display. It sits between the debounced buttons/switches and the CPU datapath, and replaces direct button-as-clock stepping.

---
 rtl/cpu_ctrl_pkg.sv | 32 +++
 rtl/cpu_beat_seq.sv | 52 +++++
 rtl/cpu_run_ctrl.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the CPU run/step controller.
// Contents: FSM state encoding, opcode constants, and the opcode -> beat-count decode.
// Latency: n/a (package).  Backpressure: n/a.
package cpu_ctrl_pkg;

  localparam int BEAT_W = 5;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J   = 6'b000010;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INSTR = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_BREAK = 3'd4
  } run_state_t;

  // Number of beats (3..5) the instruction with this opcode needs.
  function automatic logic [2:0] beat_len(input logic [5:0] op);
    case (op)
      OP_LW:        beat_len = 3'd5;
      OP_BEQ, OP_J: beat_len = 3'd3;
      OP_R, OP_SW:  beat_len = 3'd4;
      default:      beat_len = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/cpu_beat_seq.sv
// Beat sequencer: one-hot phase, binary beat index, beat/instruction counters.
// Latency: state advances on the edge that samples ce=1.  Backpressure: none, ce is the only advance.
// Ports: ce advance strobe, ir_op for length decode; beat/beat_idx/counters out, plus
//        eff_zero/eff_last describing the beat the *next* pulse would issue (accounts for a pending ce).
module cpu_beat_seq
  import cpu_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              RSTN,
  input  logic              ce,
  input  logic [5:0]        ir_op,
  output logic [BEAT_W-1:0] beat,
  output logic [2:0]        beat_idx,
  output logic [CNT_W-1:0]  beat_cnt,
  output logic [CNT_W-1:0]  instr_cnt,
  output logic              eff_zero,
  output logic              eff_last
);

  logic [2:0] len_m1;
  logic       last;

  assign len_m1 = beat_len(ir_op) - 3'd1;
  assign last   = (beat_idx == len_m1);

  // A pulse already sitting in ce will move the beat on at the next edge, so a
  // decision made now must look at the beat that follows it.
  assign eff_zero = ce ? last : (beat_idx == 3'd0);
  assign eff_last = ce ? (!last && ((beat_idx + 3'd1) == len_m1)) : last;

  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      beat      <= BEAT_W'(1);
      beat_idx  <= 3'd0;
      beat_cnt  <= '0;
      instr_cnt <= '0;
    end else if (ce) begin
      beat_cnt <= beat_cnt + CNT_W'(1);
      if (last) begin
        beat      <= BEAT_W'(1);
        beat_idx  <= 3'd0;
        instr_cnt <= instr_cnt + CNT_W'(1);
      end else begin
        beat     <= {beat[BEAT_W-2:0], 1'b0};
        beat_idx <= beat_idx + 3'd1;
      end
    end
  end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Debug run/step controller: drives the CPU clock enable and 5-beat one-hot phase.
// Latency: cpu_ce is registered, one cycle after the request/tick that causes it.  Backpressure: none.
// Ports: buttons/switches in (run_sw, step_beat_btn, step_instr_btn), ir_op/pc from the CPU,
//        bp_addr/bp_en breakpoint; cpu_ce, beat, beat_idx, counters, state_o, halted, bp_hit out.
// Optional macro CPU_RUN_BREAKPOINT_EN enables the PC breakpoint; without it BREAK is unreachable.
module cpu_run_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int RUN_DIV_LOG2 = 0,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              RSTN,
  input  logic              run_sw,
  input  logic              step_beat_btn,
  input  logic              step_instr_btn,
  input  logic [5:0]        ir_op,
  input  logic [31:0]       pc,
  input  logic [31:0]       bp_addr,
  input  logic              bp_en,
  output logic              cpu_ce,
  output logic [BEAT_W-1:0] beat,
  output logic [2:0]        beat_idx,
  output logic [CNT_W-1:0]  beat_cnt,
  output logic [CNT_W-1:0]  instr_cnt,
  output logic [2:0]        state_o,
  output logic              halted,
  output logic              bp_hit
);

  run_state_t state, state_nxt;
  logic       ce_nxt;
  logic       beat_q, instr_q;
  logic       beat_edge, instr_edge;
  logic       tick;
  logic       eff_zero, eff_last;
  logic       skip_set, skip_clr;
  logic       bp_match;

  assign beat_edge  = step_beat_btn & ~beat_q;
  assign instr_edge = step_instr_btn & ~instr_q;

  // Free-run prescaler; restarts whenever we leave RUN/DRAIN so the first
  // RUN pulse lands a full period after entry.
  generate
    if (RUN_DIV_LOG2 == 0) begin : g_nodiv
      assign tick = 1'b1;
    end else begin : g_div
      logic [RUN_DIV_LOG2-1:0] div_cnt;
      always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN)
          div_cnt <= '0;
        else if (state == ST_RUN || state == ST_DRAIN)
          div_cnt <= div_cnt + RUN_DIV_LOG2'(1);
        else
          div_cnt <= '0;
      end
      assign tick = &div_cnt;
    end
  endgenerate

`ifdef CPU_RUN_BREAKPOINT_EN
  // Set on resume so the instruction we stopped at is allowed to execute.
  logic bp_skip;
  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN)         bp_skip <= 1'b0;
    else if (skip_set) bp_skip <= 1'b1;
    else if (skip_clr) bp_skip <= 1'b0;
  end
  assign bp_match = bp_en && (pc == bp_addr) && !bp_skip;
  assign bp_hit   = (state == ST_BREAK);
`else
  logic unused_bp;
  assign unused_bp = ^{pc, bp_addr, bp_en, skip_set, skip_clr};
  assign bp_match  = 1'b0;
  assign bp_hit    = 1'b0;
`endif

  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      state   <= ST_IDLE;
      cpu_ce  <= 1'b0;
      beat_q  <= 1'b0;
      instr_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      cpu_ce  <= ce_nxt;
      beat_q  <= step_beat_btn;
      instr_q <= step_instr_btn;
    end
  end

  always_comb begin
    state_nxt = state;
    ce_nxt    = 1'b0;
    skip_set  = 1'b0;
    skip_clr  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (run_sw) begin
          state_nxt = ST_RUN;
          skip_set  = 1'b1;
        end else if (instr_edge) begin
          state_nxt = ST_INSTR;
          skip_set  = 1'b1;
        end else if (beat_edge) begin
          ce_nxt = 1'b1;
        end
      end
      ST_INSTR: begin
        if (eff_zero && bp_match) begin
          state_nxt = ST_BREAK;
        end else begin
          ce_nxt   = 1'b1;
          skip_clr = eff_zero;
          if (eff_last) state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (!run_sw) begin
          state_nxt = ST_DRAIN;
        end else if (tick) begin
          if (eff_zero && bp_match) begin
            state_nxt = ST_BREAK;
          end else begin
            ce_nxt   = 1'b1;
            skip_clr = eff_zero;
          end
        end
      end
      ST_DRAIN: begin
        // Already on an instruction boundary: nothing left to finish.
        if (eff_zero) begin
          state_nxt = ST_IDLE;
        end else if (tick) begin
          ce_nxt = 1'b1;
          if (eff_last) state_nxt = ST_IDLE;
        end
      end
      ST_BREAK: begin
        if (!run_sw) begin
          state_nxt = ST_IDLE;
        end else if (instr_edge) begin
          state_nxt = ST_INSTR;
          skip_set  = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  cpu_beat_seq #(.CNT_W(CNT_W)) u_seq (
    .clk       (clk),
    .RSTN      (RSTN),
    .ce        (cpu_ce),
    .ir_op     (ir_op),
    .beat      (beat),
    .beat_idx  (beat_idx),
    .beat_cnt  (beat_cnt),
    .instr_cnt (instr_cnt),
    .eff_zero  (eff_zero),
    .eff_last  (eff_last)
  );

  assign state_o = state;
  assign halted  = (state == ST_IDLE) || (state == ST_BREAK);

endmodule
